// File: rtl/ctr_drbg_seed_ctrl_if.sv
// Block-cipher request/response channel between the CTR_DRBG seeding
// controller (master) and an external cipher core (slave).
//   aes_req    : master -> slave, request; held until aes_ack
//   aes_key    : master -> slave, cipher key, stable while aes_req is high
//   aes_block  : master -> slave, plaintext block, stable while aes_req is high
//   aes_ack    : slave -> master, completion; aes_result valid in same cycle
//   aes_result : slave -> master, ciphertext block
interface ctr_drbg_seed_ctrl_if #(
  parameter int unsigned KEY_W = 256
);
  logic             aes_req;
  logic [KEY_W-1:0] aes_key;
  logic [127:0]     aes_block;
  logic             aes_ack;
  logic [127:0]     aes_result;

  modport master (
    output aes_req, aes_key, aes_block,
    input  aes_ack, aes_result
  );

  modport slave (
    input  aes_req, aes_key, aes_block,
    output aes_ack, aes_result
  );
endinterface

// File: rtl/ctr_drbg_seed_ctrl.sv
// CTR_DRBG (no derivation function) seeding controller. Runs Instantiate
// (mode=0) and Reseed (mode=1) through one CTR_DRBG_Update sequencer, driving
// an external block cipher, and owns the DRBG working state Key/V/counter.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   start, mode        : request pulse (sampled in IDLE) and operation select
//   entropy, pers_add  : seed material, sampled with start (SEED_W bits each)
//   gen_inc            : one pulse per completed generate request
//   busy, done, err    : status; done/err are one-cycle pulses
//   aes                : cipher channel (master side)
//   key, value         : committed Key and V
//   reseedcounter      : reseed counter (saturating)
//   instantiated       : set by a successful instantiate
//   reseed_needed      : instantiated && reseedcounter > RESEED_INTERVAL
module ctr_drbg_seed_ctrl #(
  parameter int unsigned  KEY_W           = 256,
  parameter logic [31:0]  RESEED_INTERVAL = 32'h0001_0000,
  localparam int unsigned SEED_W          = KEY_W + 128,
  localparam int unsigned NBLK            = SEED_W / 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [SEED_W-1:0]   entropy,
  input  logic [SEED_W-1:0]   pers_add,
  input  logic                gen_inc,
  output logic                busy,
  output logic                done,
  output logic                err,
  ctr_drbg_seed_ctrl_if.master aes,
  output logic [KEY_W-1:0]    key,
  output logic [127:0]        value,
  output logic [31:0]         reseedcounter,
  output logic                instantiated,
  output logic                reseed_needed
);

  if (KEY_W != 128 && KEY_W != 256) begin : g_bad_key_w
    $error("ctr_drbg_seed_ctrl: KEY_W must be 128 or 256");
  end

  localparam logic [1:0] LAST_BLK = 2'(NBLK - 1);

  typedef enum logic [1:0] {IDLE, INC, ENC, UPD} state_t;

  state_t            state;
  logic [SEED_W-1:0] seed;
  logic [KEY_W-1:0]  kw;
  logic [127:0]      vw;
  logic [SEED_W-1:0] temp;
  logic [1:0]        blk_idx;

  assign reseed_needed = instantiated && (reseedcounter > RESEED_INTERVAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      seed          <= '0;
      kw            <= '0;
      vw            <= '0;
      temp          <= '0;
      blk_idx       <= '0;
      key           <= '0;
      value         <= '0;
      reseedcounter <= 32'd1;
      instantiated  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      aes.aes_req   <= 1'b0;
      aes.aes_key   <= '0;
      aes.aes_block <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      if (state == IDLE && instantiated && gen_inc && reseedcounter != '1) begin
        reseedcounter <= reseedcounter + 32'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (!mode) begin
              seed    <= entropy ^ pers_add;
              kw      <= '0;
              vw      <= '0;
              blk_idx <= '0;
              busy    <= 1'b1;
              state   <= INC;
            end else if (instantiated) begin
              seed    <= entropy ^ pers_add;
              kw      <= key;
              vw      <= value;
              blk_idx <= '0;
              busy    <= 1'b1;
              state   <= INC;
            end else begin
              err <= 1'b1;
            end
          end
        end

        INC: begin
          // The cipher operands are registered here so they stay frozen for
          // the whole ENC wait, however long the ack takes.
          vw            <= vw + 128'd1;
          aes.aes_req   <= 1'b1;
          aes.aes_key   <= kw;
          aes.aes_block <= vw + 128'd1;
          state         <= ENC;
        end

        ENC: begin
          if (aes.aes_ack) begin
            // Shift in from the bottom: after NBLK blocks, block 0 sits in
            // the MSBs of temp.
            temp        <= {temp[SEED_W-129:0], aes.aes_result};
            aes.aes_req <= 1'b0;
            if (blk_idx == LAST_BLK) begin
              state <= UPD;
            end else begin
              blk_idx <= blk_idx + 2'd1;
              state   <= INC;
            end
          end
        end

        UPD: begin
          key           <= temp[SEED_W-1:128] ^ seed[SEED_W-1:128];
          value         <= temp[127:0] ^ seed[127:0];
          // Overrides any gen_inc increment scheduled above.
          reseedcounter <= 32'd1;
          instantiated  <= 1'b1;
          done          <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctr_drbg_seed_ctrl.sv
// Bench for ctr_drbg_seed_ctrl: one KEY_W=256 instance (RESEED_INTERVAL=2)
// and one KEY_W=128 instance (default interval), each with a cipher stub
// computing aes_block ^ aes_key[127:0] after a programmable ack delay.
// A "sel" view multiplexes the active instance for the shared check tasks.
module tb_ctr_drbg_seed_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode;
  logic         gen_inc;
  logic         sel;
  logic [383:0] entropy;
  logic [383:0] pers_add;
  int           dly;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  // Instance A: KEY_W = 256
  ctr_drbg_seed_ctrl_if #(.KEY_W(256)) if_a ();
  logic         a_busy, a_done, a_err, a_inst, a_rn;
  logic [255:0] a_key;
  logic [127:0] a_value;
  logic [31:0]  a_cnt;
  int           a_wait;

  ctr_drbg_seed_ctrl #(.KEY_W(256), .RESEED_INTERVAL(32'd2)) u_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .mode(mode),
    .entropy(entropy), .pers_add(pers_add), .gen_inc(gen_inc & ~sel),
    .busy(a_busy), .done(a_done), .err(a_err), .aes(if_a.master),
    .key(a_key), .value(a_value), .reseedcounter(a_cnt),
    .instantiated(a_inst), .reseed_needed(a_rn)
  );

  assign if_a.aes_result = if_a.aes_block ^ if_a.aes_key[127:0];
  assign if_a.aes_ack    = if_a.aes_req && (a_wait == dly);
  always @(posedge clk or posedge rst) begin
    if (rst) a_wait <= 0;
    else if (!if_a.aes_req || if_a.aes_ack) a_wait <= 0;
    else a_wait <= a_wait + 1;
  end

  // Instance B: KEY_W = 128
  ctr_drbg_seed_ctrl_if #(.KEY_W(128)) if_b ();
  logic         b_busy, b_done, b_err, b_inst, b_rn;
  logic [127:0] b_key;
  logic [127:0] b_value;
  logic [31:0]  b_cnt;
  int           b_wait;

  ctr_drbg_seed_ctrl #(.KEY_W(128)) u_b (
    .clk(clk), .rst(rst), .start(start & sel), .mode(mode),
    .entropy(entropy[255:0]), .pers_add(pers_add[255:0]), .gen_inc(gen_inc & sel),
    .busy(b_busy), .done(b_done), .err(b_err), .aes(if_b.master),
    .key(b_key), .value(b_value), .reseedcounter(b_cnt),
    .instantiated(b_inst), .reseed_needed(b_rn)
  );

  assign if_b.aes_result = if_b.aes_block ^ if_b.aes_key;
  assign if_b.aes_ack    = if_b.aes_req && (b_wait == dly);
  always @(posedge clk or posedge rst) begin
    if (rst) b_wait <= 0;
    else if (!if_b.aes_req || if_b.aes_ack) b_wait <= 0;
    else b_wait <= b_wait + 1;
  end

  // Selected view
  logic         v_busy, v_done, v_err, v_inst, v_rn, v_req, v_ack;
  logic [255:0] v_key, v_akey;
  logic [127:0] v_value, v_block;
  logic [31:0]  v_cnt;
  assign v_busy  = sel ? b_busy : a_busy;
  assign v_done  = sel ? b_done : a_done;
  assign v_err   = sel ? b_err  : a_err;
  assign v_inst  = sel ? b_inst : a_inst;
  assign v_rn    = sel ? b_rn   : a_rn;
  assign v_key   = sel ? {128'b0, b_key} : a_key;
  assign v_value = sel ? b_value : a_value;
  assign v_cnt   = sel ? b_cnt : a_cnt;
  assign v_req   = sel ? if_b.aes_req : if_a.aes_req;
  assign v_ack   = sel ? if_b.aes_ack : if_a.aes_ack;
  assign v_akey  = sel ? {128'b0, if_b.aes_key} : if_a.aes_key;
  assign v_block = sel ? if_b.aes_block : if_a.aes_block;

  // Reference state per instance (index 0 = A, 1 = B)
  logic [255:0] m_key [2];
  logic [127:0] m_val [2];
  logic [31:0]  m_cnt [2];
  bit           m_inst[2];

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [383:0] rand384();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_key[i] = '0; m_val[i] = '0; m_cnt[i] = 32'd1; m_inst[i] = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_key"},   v_key, 0);
    chk({tag, "_value"}, v_value, 0);
    chk({tag, "_cnt"},   v_cnt, 1);
    chk({tag, "_inst"},  v_inst, 0);
    chk({tag, "_busy"},  v_busy, 0);
    chk({tag, "_done"},  v_done, 0);
    chk({tag, "_err"},   v_err, 0);
    chk({tag, "_req"},   v_req, 0);
    chk({tag, "_akey"},  v_akey, 0);
    chk({tag, "_block"}, v_block, 0);
    chk({tag, "_rn"},    v_rn, 0);
  endtask

  task automatic gen_pulses(input int n);
    int s;
    logic [31:0] interval;
    s = sel ? 1 : 0;
    interval = sel ? 32'h0001_0000 : 32'd2;
    for (int i = 0; i < n; i++) begin
      gen_inc = 1'b1;
      @(negedge clk);
      gen_inc = 1'b0;
      if (m_inst[s] && m_cnt[s] != 32'hFFFF_FFFF) m_cnt[s] = m_cnt[s] + 32'd1;
      if ($urandom_range(1) == 1) @(negedge clk);
    end
    chk("gen_cnt", v_cnt, m_cnt[s]);
    chk("gen_rn",  v_rn, (m_inst[s] && m_cnt[s] > interval) ? 1 : 0);
  endtask

  // One instantiate/reseed request on the selected instance. With poke set,
  // start, gen_inc and new entropy are thrown at the DUT while it is busy.
  task automatic run_op(input bit md, input logic [383:0] ent, input logic [383:0] pa,
                        input int d, input bit poke);
    int s, nb, lat, n, ridx;
    logic [255:0] k0, newkey;
    logic [127:0] v0, newval;
    logic [383:0] seedv, t;
    logic [127:0] blk[3];
    s  = sel ? 1 : 0;
    nb = sel ? 2 : 3;
    lat = 2 * nb + 1 + nb * d;
    seedv = ent ^ pa;
    if (sel) seedv[383:256] = '0;

    dly = d; mode = md; entropy = ent; pers_add = pa; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;

    if (md && !m_inst[s]) begin
      chk("err_pulse", v_err, 1);
      chk("err_busy", v_busy, 0);
      @(negedge clk);
      chk("err_clear", v_err, 0);
      chk("err_busy2", v_busy, 0);
      chk("err_key", v_key, m_key[s]);
      chk("err_value", v_value, m_val[s]);
      chk("err_inst", v_inst, 0);
      return;
    end

    k0 = md ? m_key[s] : '0;
    v0 = md ? m_val[s] : '0;
    for (int b = 0; b < nb; b++) blk[b] = (v0 + 128'(b + 1)) ^ k0[127:0];
    if (nb == 3) begin
      t = {blk[0], blk[1], blk[2]} ^ seedv;
      newkey = t[383:128];
    end else begin
      t = {128'b0, blk[0], blk[1]} ^ seedv;
      newkey = {128'b0, t[255:128]};
    end
    newval = t[127:0];

    n = 0; ridx = 0;
    while (v_done !== 1'b1 && n <= lat + 20) begin
      chk("busy", v_busy, 1);
      if (v_req === 1'b1) begin
        chk("aes_key", v_akey, k0);
        chk("aes_block", v_block, v0 + 128'(ridx + 1));
        if (v_ack === 1'b1) ridx++;
      end
      if (poke && n == 1) begin
        gen_inc = 1'b1; start = 1'b1; entropy = rand384();
      end else begin
        gen_inc = 1'b0; start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    gen_inc = 1'b0; start = 1'b0;

    chk("latency", n, lat);
    chk("blocks", ridx, nb);
    chk("done", v_done, 1);
    chk("busy_at_done", v_busy, 0);
    chk("key", v_key, newkey);
    chk("value", v_value, newval);
    chk("cnt", v_cnt, 1);
    chk("inst", v_inst, 1);
    chk("rn", v_rn, 0);
    m_key[s] = newkey; m_val[s] = newval; m_cnt[s] = 32'd1; m_inst[s] = 1'b1;

    @(negedge clk);
    chk("done_pulse", v_done, 0);
    chk("no_requeue", v_busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; gen_inc = 1'b0; sel = 1'b0;
    entropy = '0; pers_add = '0; dly = 0;
    model_reset();
    repeat (2) @(negedge clk);
    sel = 1'b0; check_reset_outputs("rst_a");
    sel = 1'b1; check_reset_outputs("rst_b");
    rst = 1'b0;
    @(negedge clk);

    // KEY_W=256: reseed before instantiate, then the known-answer sequence
    sel = 1'b0;
    run_op(1'b1, '0, '0, 0, 1'b0);
    run_op(1'b0, '0, '0, 0, 1'b0);
    chk("kat_inst_key", a_key, {128'h1, 128'h2});
    chk("kat_inst_value", a_value, 128'h3);
    run_op(1'b1, '0, '0, 0, 1'b0);
    chk("kat_reseed_key", a_key, {128'h6, 128'h7});
    chk("kat_reseed_value", a_value, 128'h4);

    // Interval boundary: equal is not yet "needed"
    gen_pulses(1);
    chk("boundary_eq_rn", a_rn, 0);
    gen_pulses(1);
    chk("boundary_gt_rn", a_rn, 1);
    run_op(1'b1, rand384(), rand384(), 1, 1'b1);
    chk("reseed_clears_rn", a_rn, 0);

    for (int i = 0; i < 6; i++) begin
      run_op(1'($urandom_range(1)), rand384(), rand384(), int'($urandom_range(3)),
             1'($urandom_range(1)));
      gen_pulses(int'($urandom_range(3)));
    end

    // KEY_W=128: known answer with a 3-cycle ack delay, then random
    sel = 1'b1;
    run_op(1'b0, '0, '0, 3, 1'b0);
    chk("kat128_key", b_key, 128'h1);
    chk("kat128_value", b_value, 128'h2);
    for (int i = 0; i < 3; i++) begin
      gen_pulses(int'($urandom_range(2)));
      run_op(1'($urandom_range(1)), rand384(), rand384(), int'($urandom_range(2)),
             1'($urandom_range(1)));
    end

    // Asynchronous reset during the second ENC of an instantiate
    sel = 1'b0;
    dly = 0; mode = 1'b0; entropy = rand384(); pers_add = rand384(); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_req", v_req, 1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("abort_a");
    sel = 1'b1; check_reset_outputs("abort_b");
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check_reset_outputs("no_commit");
    run_op(1'b0, rand384(), rand384(), 1, 1'b0);

    sel = 1'b1;
    run_op(1'b1, rand384(), rand384(), 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
